// File: rtl/pu_mb_sched.sv
// pu_mb_sched: multi-bank open-page DDR command scheduler with
// per-bank tRCD/tRP timers, write-starvation arbitration, read/write
// turnaround and a CL/CWL SerDes data-window shift register.
// Ports: clk, rst (sync, active-high); rd_/wr_adrs + rd_/wr_mt FWFT
// queue heads; rd_en/wr_en comb pops; C_S, adrs_out, valid,
// rw_mux_sel registered command side; SerDes_en/sel, busy data side.
module pu_mb_sched #(
  parameter int NB        = 4,
  parameter int COL_W     = 10,
  parameter int ROW_W     = 16,
  parameter int CL        = 4,
  parameter int CWL       = 3,
  parameter int BL        = 4,
  parameter int t_act     = 8,
  parameter int t_pre     = 8,
  parameter int TURN      = 2,
  parameter int WR_STARVE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_adrs,
  input  logic [31:0] wr_adrs,
  input  logic        rd_mt,
  input  logic        wr_mt,
  output logic        rd_en,
  output logic        wr_en,
  output logic [3:0]  C_S,
  output logic [31:0] adrs_out,
  output logic        valid,
  output logic        rw_mux_sel,
  output logic        SerDes_en,
  output logic        SerDes_sel,
  output logic        busy
);

  localparam int BW   = $clog2(NB);
  localparam int TMAX = (t_act > t_pre) ? t_act : t_pre;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(BL + TURN + 1);
  localparam int SW   = $clog2(WR_STARVE + 1);
  localparam int D    = ((CL > CWL) ? CL : CWL) + BL;

  localparam logic [D-1:0] BURST = D'((1 << BL) - 1);
  localparam logic [D-1:0] RMASK = BURST << CL;
  localparam logic [D-1:0] WMASK = BURST << CWL;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ACT = 4'd1,
    CMD_PRE = 4'd2,
    CMD_RD  = 4'd3,
    CMD_WR  = 4'd4
  } cmd_e;

  cmd_e              cmd_q, cmd_d;
  logic [31:0]       adrs_q, adrs_d;
  logic              valid_q, valid_d;
  logic              dir_q, dir_d;
  logic [NB-1:0]     open_q, open_d;
  logic [ROW_W-1:0]  row_q [NB];
  logic [ROW_W-1:0]  row_d [NB];
  logic [TW-1:0]     tmr_q [NB];
  logic [TW-1:0]     tmr_d [NB];
  logic [CW-1:0]     cas_q, cas_d;
  logic [CW-1:0]     turn_q, turn_d;
  logic [SW-1:0]     stv_q, stv_d;
  logic [D-1:0]      en_q, en_d;
  logic [D-1:0]      sel_q, sel_d;

  logic              cand_wr, cand_v;
  logic [31:0]       cadr;
  logic [BW-1:0]     cbank;
  logic [ROW_W-1:0]  crow;
  logic              col_ok, col_go;

  assign cand_wr = !wr_mt && (rd_mt || stv_q == SW'(WR_STARVE));
  assign cand_v  = cand_wr || !rd_mt;
  assign cadr    = cand_wr ? wr_adrs : rd_adrs;
  assign cbank   = cadr[COL_W +: BW];
  assign crow    = cadr[COL_W+BW +: ROW_W];

  // cas_q spaces same-direction bursts (tCCD); turn_q is the
  // longer gap a direction change must additionally wait out.
  assign col_ok = (cas_q == '0) &&
                  ((cand_wr == dir_q) || (turn_q == '0));

  always_comb begin
    cmd_d   = CMD_NOP;
    adrs_d  = adrs_q;
    valid_d = 1'b0;
    dir_d   = dir_q;
    open_d  = open_q;
    row_d   = row_q;
    stv_d   = stv_q;
    col_go  = 1'b0;
    cas_d   = (cas_q != '0) ? cas_q - CW'(1) : '0;
    turn_d  = (turn_q != '0) ? turn_q - CW'(1) : '0;
    en_d    = en_q >> 1;
    sel_d   = sel_q >> 1;
    for (int b = 0; b < NB; b++) begin
      tmr_d[b] = (tmr_q[b] != '0) ? tmr_q[b] - TW'(1) : '0;
    end
    // A busy bank stalls the candidate; no fallback to the other queue.
    if (cand_v && tmr_q[cbank] == '0) begin
      unique case (1'b1)
        !open_q[cbank]: begin
          cmd_d         = CMD_ACT;
          open_d[cbank] = 1'b1;
          row_d[cbank]  = crow;
          tmr_d[cbank]  = TW'(t_act - 1);
        end
        open_q[cbank] && row_q[cbank] != crow
          && cas_q == '0: begin
          cmd_d         = CMD_PRE;
          open_d[cbank] = 1'b0;
          tmr_d[cbank]  = TW'(t_pre - 1);
        end
        open_q[cbank] && row_q[cbank] == crow
          && col_ok: begin
          col_go  = 1'b1;
          cmd_d   = cand_wr ? CMD_WR : CMD_RD;
          adrs_d  = cadr;
          valid_d = 1'b1;
          dir_d   = cand_wr;
          cas_d   = CW'(BL - 1);
          turn_d  = CW'(BL + TURN - 1);
          en_d    = en_d | (cand_wr ? WMASK : RMASK);
          sel_d   = sel_d | (cand_wr ? WMASK : '0);
          if (cand_wr) begin
            stv_d = '0;
          end else if (!wr_mt && stv_q != SW'(WR_STARVE)) begin
            stv_d = stv_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= CMD_NOP;
      adrs_q  <= '0;
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      open_q  <= '0;
      cas_q   <= '0;
      turn_q  <= '0;
      stv_q   <= '0;
      en_q    <= '0;
      sel_q   <= '0;
      for (int b = 0; b < NB; b++) begin
        row_q[b] <= '0;
        tmr_q[b] <= '0;
      end
    end else begin
      cmd_q   <= cmd_d;
      adrs_q  <= adrs_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      open_q  <= open_d;
      cas_q   <= cas_d;
      turn_q  <= turn_d;
      stv_q   <= stv_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      tmr_q   <= tmr_d;
    end
  end

  assign rd_en      = col_go && !cand_wr && !rst;
  assign wr_en      = col_go && cand_wr && !rst;
  assign C_S        = cmd_q;
  assign adrs_out   = adrs_q;
  assign valid      = valid_q;
  assign rw_mux_sel = dir_q;
  assign SerDes_en  = en_q[0];
  assign SerDes_sel = sel_q[0];
  assign busy       = |en_q;

endmodule

// File: doc/pu_mb_sched.md
Name: pu_mb_sched

Overview:
- Next-generation DDR5 processing unit: a multi-bank, open-page command scheduler with an integrated CAS-latency data-window pipeline.
- Consumes first-word-fall-through (FWFT) read/write request queues and tracks open rows per bank with independent tRCD/tRP timers.
- Issues ACT/PRE/RD/WR on C_S and drives the SerDes enable/direction window for reads (CL) and writes (CWL).
- Adds over the previous unit: per-bank row-hit detection, write-starvation arbitration, separate read/write latencies, and bus-turnaround enforcement.

Parameters:
- NB, 4, number of banks (power of 2, 2..16)
- COL_W, 10, column field width (address bits [COL_W-1:0])
- ROW_W, 16, row field width (bits above the bank field)
- CL, 4, read latency: RD command to first read data cycle
- CWL, 3, write latency: WR command to first write data cycle
- BL, 4, data burst length in cycles; also tCCD
- t_act, 8, ACT to first column command to same bank (tRCD)
- t_pre, 8, PRE to next ACT to same bank (tRP)
- TURN, 2, extra gap on read/write direction change; constraint |CL-CWL| <= TURN
- WR_STARVE, 8, consecutive read column commands tolerated while writes wait

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_adrs  in  32  head of read queue; bank = [COL_W +: log2(NB)], row = next ROW_W bits
- wr_adrs  in  32  head of write queue, same field split
- rd_mt  in  1  read queue empty
- wr_mt  in  1  write queue empty
- rd_en  out  1  combinational pop of read queue, high in the cycle an RD is decided
- wr_en  out  1  combinational pop of write queue
- C_S  out  4  registered command: 0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR
- adrs_out  out  32  registered address of the issued command
- valid  out  1  registered; 1 for a cycle carrying RD/WR
- rw_mux_sel  out  1  registered direction of the last column command (1 = write)
- SerDes_en  out  1  data window active
- SerDes_sel  out  1  window direction (1 = write)
- busy  out  1  any data window pending or active

Behaviour:
- Reset, synchronous, active-high:
  - All outputs 0; C_S = NOP.
  - All banks closed; bank timers, cas timer and starvation counter 0; data pipeline cleared.
  - Reset asserted mid-burst aborts the window on the next cycle.
- Candidate selection each cycle:
  - Write if rd_mt=1 and wr_mt=0.
  - Write if wr_mt=0 and starve_cnt == WR_STARVE.
  - Otherwise read if rd_mt=0.
  - Both queues empty: NOP.
- Bank b of the candidate, in priority order:
  - Timer[b] != 0: NOP; the candidate holds, no pop, no fallback to the other queue.
  - Closed: issue ACT; open[b] = 1, row[b] = candidate row, timer[b] = t_act.
  - Open with a different row, and cas timer == 0: issue PRE; open[b] = 0, timer[b] = t_pre.
  - Open with the same row, and cas timer == 0: issue RD or WR; pop the queue; valid = 1; adrs_out = candidate address.
- Cas timer:
  - Loaded after each column command: BL for the same direction as the last one, BL+TURN when the direction changes.
  - The first column command after reset counts as same-direction.
  - A column command is allowed only when the cas timer is 0 and the pending direction check passes.
- Timers decrement by 1 per cycle and saturate at 0.
- Starvation counter:
  - Increments on an RD issued while wr_mt=0.
  - Clears on any WR.
  - Saturates at WR_STARVE.
- Data pipeline, with E = cycle in which C_S shows RD/WR:
  - RD: SerDes_en = 1, SerDes_sel = 0 in cycles E+CL .. E+CL+BL-1.
  - WR: SerDes_en = 1, SerDes_sel = 1 in cycles E+CWL .. E+CWL+BL-1.
  - Windows never overlap under the TURN constraint.
  - Implemented as a shift register of depth max(CL,CWL)+BL.
- At most one command per cycle. Adrs_out holds its last value on NOP, ACT and PRE cycles.

Test Plan:
- Reset, rd_adrs = bank 0 row 5 col 0x10, rd_mt = 0 at cycle 0 -> ACT at E0; RD at E0+8 with valid = 1, rd_en for one cycle; SerDes_en = 1, sel = 0 for cycles E0+12..E0+15.
- Second read, same bank and row, presented right after the first RD -> RD exactly 4 cycles after the first; no ACT/PRE issued.
- Read to bank 0 row 7 while row 5 is open -> PRE, ACT 8 cycles later, RD 8 cycles after that.
- WR issued 4 cycles after an RD (direction change) -> blocked; WR issued 6 cycles after the RD; write window starts 3 cycles after the WR; no overlap with the read window.
- Continuous reads with wr_mt = 0 -> exactly 8 RDs, then one WR, then reads resume.
- Reset asserted during an active read window -> SerDes_en, busy and C_S at 0 on the next cycle; a new request re-ACTs because all banks are closed.
